// File: rtl/sentence_emitter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sentence_emitter_pkg
//  Description : Shared definitions for the NMEA-style sentence emitter:
//                frame state encoding and the fixed ASCII framing characters.
//  Revision    : 1.0 - initial release
// ============================================================================
package sentence_emitter_pkg;

  // Frame sequencing, one state per emitted field.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DOLLAR = 3'd1,
    ST_BODY   = 3'd2,
    ST_STAR   = 3'd3,
    ST_HI     = 3'd4,
    ST_LO     = 3'd5,
    ST_CR     = 3'd6,
    ST_LF     = 3'd7
  } state_e;

  localparam logic [7:0] CHAR_DOLLAR = 8'h24;  // "$"
  localparam logic [7:0] CHAR_STAR   = 8'h2A;  // "*"
  localparam logic [7:0] CHAR_CR     = 8'h0D;
  localparam logic [7:0] CHAR_LF     = 8'h0A;

endpackage
`default_nettype wire

// File: rtl/sentence_emitter_nibble_to_ascii.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_to_ascii
//  Description : Combinational 4-bit value to upper-case ASCII hex digit.
//  Ports       : nibble [3:0] in  - value 0..15
//                ascii  [7:0] out - "0".."9", "A".."F"
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // 8'h37 + 10 == "A"
  assign ascii = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                  : (8'h37 + {4'h0, nibble});

endmodule
`default_nettype wire

// File: rtl/sentence_emitter.sv
`default_nettype none
// ============================================================================
//  Module      : sentence_emitter
//  Description : Serialises one sentence "$<Ref>*HH<CR><LF>" per start
//                request over a load/ready byte handshake. HH is the XOR of
//                the body bytes in upper-case hex; the "*HH" field is
//                omitted when CHECKSUM == 0.
//  Ports       : clock   in      rising-edge clock
//                restart in      synchronous active-high reset / abort
//                start   in      request a sentence (sampled while idle)
//                ready   in      sink accepts data when load && ready
//                data    out [8] current byte (held while load==0)
//                load    out     data valid
//                busy    out     frame in progress
//                done    out     one-cycle pulse after LF accepted
//  Revision    : 1.0 - initial release
// ============================================================================
module sentence_emitter
  import sentence_emitter_pkg::*;
#(
  parameter int             L        = 3,
  parameter logic [8*L-1:0] Ref      = "ABC",
  parameter bit             CHECKSUM = 1'b1
) (
  input  logic       clock,
  input  logic       restart,
  input  logic       start,
  input  logic       ready,
  output logic [7:0] data,
  output logic       load,
  output logic       busy,
  output logic       done
);

  localparam int             IW       = (L > 1) ? $clog2(L) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(L - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    data_q, data_d;
  logic          load_q, load_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          accept;
  logic [IW-1:0] body_sel;
  logic [7:0]    body_byte;
  logic [3:0]    hex_nibble;
  logic [7:0]    hex_ascii;

  assign accept = load_q & ready;

  // The output register is loaded with the byte of the state being entered,
  // so the body byte needed is the one after the current index (or the first
  // one when entering BODY from DOLLAR).
  assign body_sel = (state_q == ST_BODY) ? (idx_q + 1'b1) : '0;

  always_comb begin
    body_byte = 8'h00;
    for (int j = 0; j < L; j++) begin
      if (body_sel == IW'(j)) begin
        body_byte = Ref[8*(L-1-j) +: 8];
      end
    end
  end

  // While in STAR the next byte is the high digit; in HI it is the low one.
  assign hex_nibble = (state_q == ST_STAR) ? csum_q[7:4] : csum_q[3:0];

  nibble_to_ascii u_hex (
    .nibble (hex_nibble),
    .ascii  (hex_ascii)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    data_d  = data_q;
    load_d  = load_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DOLLAR;
          data_d  = CHAR_DOLLAR;
          load_d  = 1'b1;
          busy_d  = 1'b1;
          csum_d  = 8'h00;
          idx_d   = '0;
        end
      end
      ST_DOLLAR: begin
        if (accept) begin
          state_d = ST_BODY;
          data_d  = body_byte;
        end
      end
      ST_BODY: begin
        if (accept) begin
          csum_d = csum_q ^ data_q;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (CHECKSUM) begin
              state_d = ST_STAR;
              data_d  = CHAR_STAR;
            end else begin
              state_d = ST_CR;
              data_d  = CHAR_CR;
            end
          end else begin
            idx_d  = idx_q + 1'b1;
            data_d = body_byte;
          end
        end
      end
      ST_STAR: begin
        if (accept) begin
          state_d = ST_HI;
          data_d  = hex_ascii;
        end
      end
      ST_HI: begin
        if (accept) begin
          state_d = ST_LO;
          data_d  = hex_ascii;
        end
      end
      ST_LO: begin
        if (accept) begin
          state_d = ST_CR;
          data_d  = CHAR_CR;
        end
      end
      ST_CR: begin
        if (accept) begin
          state_d = ST_LF;
          data_d  = CHAR_LF;
        end
      end
      ST_LF: begin
        if (accept) begin
          state_d = ST_IDLE;
          load_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (restart) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      csum_q  <= 8'h00;
      data_q  <= 8'h00;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      data_q  <= data_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data = data_q;
  assign load = load_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire
